// File: rtl/dmem_rsp_collector.sv
`default_nettype none
// ============================================================================
// Module   : dmem_rsp_collector
// Purpose  : Gathers per-lane TileLink D beats of outstanding loads by source
//            tag and issues one packed dcache response per request.
// Revision : 1.0
// ============================================================================
module dmem_rsp_collector #(
    parameter int NUM_LANES   = 4,
    parameter int TAG_WIDTH   = 10,
    parameter int DATA_WIDTH  = 32,
    parameter int NUM_ENTRIES = 4
) (
    input  logic                            clk_i,
    input  logic                            rst_ni,
    input  logic                            alloc_valid_i,
    input  logic [TAG_WIDTH-1:0]            alloc_tag_i,
    input  logic [NUM_LANES-1:0]            alloc_tmask_i,
    output logic                            alloc_ready_o,
    input  logic [NUM_LANES-1:0]            lane_d_valid_i,
    input  logic [NUM_LANES*3-1:0]          lane_d_opcode_i,
    input  logic [NUM_LANES*TAG_WIDTH-1:0]  lane_d_source_i,
    input  logic [NUM_LANES*DATA_WIDTH-1:0] lane_d_data_i,
    output logic [NUM_LANES-1:0]            lane_d_ready_o,
    output logic                            rsp_valid_o,
    output logic [TAG_WIDTH-1:0]            rsp_tag_o,
    output logic [NUM_LANES-1:0]            rsp_tmask_o,
    output logic [NUM_LANES*DATA_WIDTH-1:0] rsp_data_o,
    input  logic                            rsp_ready_i,
    output logic                            err_unexpected_o
);

    localparam int         IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1;
    localparam logic [2:0] OP_ACK      = 3'd0;
    localparam logic [2:0] OP_ACK_DATA = 3'd1;

    typedef enum logic [1:0] {
        ST_FREE     = 2'd0,
        ST_PENDING  = 2'd1,
        ST_COMPLETE = 2'd2
    } entry_state_e;

    entry_state_e          state_q [NUM_ENTRIES];
    entry_state_e          state_d [NUM_ENTRIES];
    logic [TAG_WIDTH-1:0]  tag_q   [NUM_ENTRIES];
    logic [TAG_WIDTH-1:0]  tag_d   [NUM_ENTRIES];
    logic [NUM_LANES-1:0]  exp_q   [NUM_ENTRIES];
    logic [NUM_LANES-1:0]  exp_d   [NUM_ENTRIES];
    logic [NUM_LANES-1:0]  recv_q  [NUM_ENTRIES];
    logic [NUM_LANES-1:0]  recv_d  [NUM_ENTRIES];
    logic [DATA_WIDTH-1:0] data_q  [NUM_ENTRIES][NUM_LANES];
    logic [DATA_WIDTH-1:0] data_d  [NUM_ENTRIES][NUM_LANES];

    logic             lock_q, lock_d;
    logic [IDX_W-1:0] lock_idx_q, lock_idx_d;
    logic             err_q, err_d;
    logic             ready_q;

    logic             free_found;
    logic [IDX_W-1:0] free_idx;
    logic             tag_busy;
    logic             cmp_found;
    logic [IDX_W-1:0] cmp_idx;
    logic             alloc_fire;
    logic [IDX_W-1:0] rsp_idx;
    logic             rsp_fire;
    logic             err_beat;
    logic             lane_match;
    logic [NUM_LANES-1:0] beat_hit [NUM_ENTRIES];

    // Lowest FREE slot, tag-collision detect, lowest COMPLETE slot.
    always_comb begin
        free_found = 1'b0;
        free_idx   = '0;
        tag_busy   = 1'b0;
        cmp_found  = 1'b0;
        cmp_idx    = '0;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            if (state_q[e] == ST_FREE) begin
                if (!free_found) begin
                    free_found = 1'b1;
                    free_idx   = IDX_W'(e);
                end
            end else if (tag_q[e] == alloc_tag_i) begin
                tag_busy = 1'b1;
            end
            if (state_q[e] == ST_COMPLETE && !cmp_found) begin
                cmp_found = 1'b1;
                cmp_idx   = IDX_W'(e);
            end
        end
    end

    assign alloc_ready_o = free_found && !tag_busy;
    assign alloc_fire    = alloc_valid_i && alloc_ready_o && (|alloc_tmask_i);

    // A presented response is pinned to its slot until it fires.
    assign rsp_idx     = lock_q ? lock_idx_q : cmp_idx;
    assign rsp_valid_o = cmp_found;
    assign rsp_fire    = rsp_valid_o && rsp_ready_i;

    // Per-lane beat matching against registered entry state only.
    always_comb begin
        err_beat   = 1'b0;
        lane_match = 1'b0;
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            beat_hit[e] = '0;
        end
        for (int i = 0; i < NUM_LANES; i++) begin
            lane_match = 1'b0;
            if (ready_q && lane_d_valid_i[i]) begin
                if (lane_d_opcode_i[i*3 +: 3] == OP_ACK_DATA) begin
                    for (int e = 0; e < NUM_ENTRIES; e++) begin
                        if (state_q[e] == ST_PENDING &&
                            tag_q[e] == lane_d_source_i[i*TAG_WIDTH +: TAG_WIDTH] &&
                            exp_q[e][i] && !recv_q[e][i]) begin
                            beat_hit[e][i] = 1'b1;
                            lane_match     = 1'b1;
                        end
                    end
                    if (!lane_match) begin
                        err_beat = 1'b1;
                    end
                end else if (lane_d_opcode_i[i*3 +: 3] != OP_ACK) begin
                    err_beat = 1'b1;
                end
            end
        end
    end

    // Entry FSM next state.
    always_comb begin
        for (int e = 0; e < NUM_ENTRIES; e++) begin
            state_d[e] = state_q[e];
            tag_d[e]   = tag_q[e];
            exp_d[e]   = exp_q[e];
            recv_d[e]  = recv_q[e];
            for (int i = 0; i < NUM_LANES; i++) begin
                data_d[e][i] = data_q[e][i];
            end
            case (state_q[e])
                ST_FREE: begin
                    if (alloc_fire && free_idx == IDX_W'(e)) begin
                        state_d[e] = ST_PENDING;
                        tag_d[e]   = alloc_tag_i;
                        exp_d[e]   = alloc_tmask_i;
                        recv_d[e]  = '0;
                        for (int i = 0; i < NUM_LANES; i++) begin
                            data_d[e][i] = '0;
                        end
                    end
                end
                ST_PENDING: begin
                    recv_d[e] = recv_q[e] | beat_hit[e];
                    for (int i = 0; i < NUM_LANES; i++) begin
                        if (beat_hit[e][i]) begin
                            data_d[e][i] = lane_d_data_i[i*DATA_WIDTH +: DATA_WIDTH];
                        end
                    end
                    if ((recv_q[e] | beat_hit[e]) == exp_q[e]) begin
                        state_d[e] = ST_COMPLETE;
                    end
                end
                ST_COMPLETE: begin
                    if (rsp_fire && rsp_idx == IDX_W'(e)) begin
                        state_d[e] = ST_FREE;
                    end
                end
                default: begin
                    state_d[e] = ST_FREE;
                end
            endcase
        end
    end

    always_comb begin
        lock_d     = lock_q;
        lock_idx_d = lock_idx_q;
        if (rsp_fire) begin
            lock_d = 1'b0;
        end else if (rsp_valid_o) begin
            lock_d     = 1'b1;
            lock_idx_d = rsp_idx;
        end
        err_d = err_q | err_beat;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                state_q[e] <= ST_FREE;
                tag_q[e]   <= '0;
                exp_q[e]   <= '0;
                recv_q[e]  <= '0;
                for (int i = 0; i < NUM_LANES; i++) begin
                    data_q[e][i] <= '0;
                end
            end
            lock_q     <= 1'b0;
            lock_idx_q <= '0;
            err_q      <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            for (int e = 0; e < NUM_ENTRIES; e++) begin
                state_q[e] <= state_d[e];
                tag_q[e]   <= tag_d[e];
                exp_q[e]   <= exp_d[e];
                recv_q[e]  <= recv_d[e];
                for (int i = 0; i < NUM_LANES; i++) begin
                    data_q[e][i] <= data_d[e][i];
                end
            end
            lock_q     <= lock_d;
            lock_idx_q <= lock_idx_d;
            err_q      <= err_d;
            ready_q    <= 1'b1;
        end
    end

    assign lane_d_ready_o   = {NUM_LANES{ready_q}};
    assign err_unexpected_o = err_q;
    assign rsp_tag_o        = rsp_valid_o ? tag_q[rsp_idx] : '0;
    assign rsp_tmask_o      = rsp_valid_o ? exp_q[rsp_idx] : '0;

    always_comb begin
        rsp_data_o = '0;
        for (int i = 0; i < NUM_LANES; i++) begin
            if (rsp_valid_o) begin
                rsp_data_o[i*DATA_WIDTH +: DATA_WIDTH] = data_q[rsp_idx][i];
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_dmem_rsp_collector.sv
`default_nettype none
// ============================================================================
// Module   : tb_dmem_rsp_collector
// Purpose  : Directed plus random bench for dmem_rsp_collector with a
//            slot-level reference model.
// Revision : 1.0
// ============================================================================
module tb_dmem_rsp_collector;

    localparam int NL = 4;
    localparam int TW = 10;
    localparam int DW = 32;
    localparam int NE = 4;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             alloc_valid;
    logic [TW-1:0]    alloc_tag;
    logic [NL-1:0]    alloc_tmask;
    logic             alloc_ready;
    logic [NL-1:0]    lane_d_valid;
    logic [NL*3-1:0]  lane_d_opcode;
    logic [NL*TW-1:0] lane_d_source;
    logic [NL*DW-1:0] lane_d_data;
    logic [NL-1:0]    lane_d_ready;
    logic             rsp_valid;
    logic [TW-1:0]    rsp_tag;
    logic [NL-1:0]    rsp_tmask;
    logic [NL*DW-1:0] rsp_data;
    logic             rsp_ready;
    logic             err_unexpected;

    int n_tests = 0;
    int n_fail  = 0;

    dmem_rsp_collector #(
        .NUM_LANES  (NL),
        .TAG_WIDTH  (TW),
        .DATA_WIDTH (DW),
        .NUM_ENTRIES(NE)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_n),
        .alloc_valid_i   (alloc_valid),
        .alloc_tag_i     (alloc_tag),
        .alloc_tmask_i   (alloc_tmask),
        .alloc_ready_o   (alloc_ready),
        .lane_d_valid_i  (lane_d_valid),
        .lane_d_opcode_i (lane_d_opcode),
        .lane_d_source_i (lane_d_source),
        .lane_d_data_i   (lane_d_data),
        .lane_d_ready_o  (lane_d_ready),
        .rsp_valid_o     (rsp_valid),
        .rsp_tag_o       (rsp_tag),
        .rsp_tmask_o     (rsp_tmask),
        .rsp_data_o      (rsp_data),
        .rsp_ready_i     (rsp_ready),
        .err_unexpected_o(err_unexpected)
    );

    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Reference model: slot status 0 free, 1 waiting for lanes, 2 ready to send.
    int            mst   [NE];
    logic [TW-1:0] mtag  [NE];
    logic [NL-1:0] mexp  [NE];
    logic [NL-1:0] mrecv [NE];
    logic [DW-1:0] mdata [NE][NL];
    bit            mheld;
    int            mheld_idx;
    bit            merr;
    bit            mready;

    task automatic m_reset();
        for (int s = 0; s < NE; s++) begin
            mst[s] = 0; mtag[s] = '0; mexp[s] = '0; mrecv[s] = '0;
            for (int l = 0; l < NL; l++) mdata[s][l] = '0;
        end
        mheld = 0; mheld_idx = 0; merr = 0; mready = 0;
    endtask

    function automatic bit m_alloc_ready(input logic [TW-1:0] t);
        bit anyfree = 0;
        bit busy    = 0;
        for (int s = 0; s < NE; s++) begin
            if (mst[s] == 0) anyfree = 1;
            else if (mtag[s] == t) busy = 1;
        end
        return anyfree && !busy;
    endfunction

    function automatic int m_rsp_idx();
        if (mheld) return mheld_idx;
        for (int s = 0; s < NE; s++) if (mst[s] == 2) return s;
        return -1;
    endfunction

    function automatic logic [NL*DW-1:0] m_rsp_data();
        logic [NL*DW-1:0] d = '0;
        int idx = m_rsp_idx();
        if (idx >= 0)
            for (int l = 0; l < NL; l++)
                if (mexp[idx][l]) d[l*DW +: DW] = mdata[idx][l];
        return d;
    endfunction

    // Advance the model by one clock edge using the inputs present at that edge.
    task automatic m_edge();
        int  idx   = m_rsp_idx();
        bit  fire  = (idx >= 0) && rsp_ready;
        bit  ar    = m_alloc_ready(alloc_tag);
        int  hit   [NL];
        for (int l = 0; l < NL; l++) begin
            hit[l] = -1;
            if (lane_d_valid[l] && mready) begin
                if (lane_d_opcode[l*3 +: 3] == 3'd1) begin
                    for (int s = 0; s < NE; s++)
                        if (mst[s] == 1 && mtag[s] == lane_d_source[l*TW +: TW] &&
                            mexp[s][l] && !mrecv[s][l]) hit[l] = s;
                    if (hit[l] < 0) merr = 1;
                end else if (lane_d_opcode[l*3 +: 3] != 3'd0) begin
                    merr = 1;
                end
            end
        end
        for (int l = 0; l < NL; l++) begin
            if (hit[l] >= 0) begin
                mrecv[hit[l]][l] = 1'b1;
                mdata[hit[l]][l] = lane_d_data[l*DW +: DW];
            end
        end
        for (int s = 0; s < NE; s++)
            if (mst[s] == 1 && mrecv[s] == mexp[s]) mst[s] = 2;
        if (alloc_valid && ar && alloc_tmask != '0) begin
            for (int s = 0; s < NE; s++) begin
                if (mst[s] == 0) begin
                    mst[s] = 1; mtag[s] = alloc_tag; mexp[s] = alloc_tmask; mrecv[s] = '0;
                    for (int l = 0; l < NL; l++) mdata[s][l] = '0;
                    break;
                end
            end
        end
        if (fire) begin
            mst[idx] = 0;
            mheld = 0;
        end else if (idx >= 0) begin
            mheld = 1;
            mheld_idx = idx;
        end
        mready = 1;
    endtask

    task automatic chk(input string name, input logic [127:0] got, input logic [127:0] exp);
        n_tests++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", name, got, exp);
        end
    endtask

    task automatic check_all();
        int idx = m_rsp_idx();
        chk("alloc_ready", 128'(alloc_ready), 128'(m_alloc_ready(alloc_tag)));
        chk("rsp_valid", 128'(rsp_valid), 128'(idx >= 0));
        chk("rsp_tag", 128'(rsp_tag), (idx >= 0) ? 128'(mtag[idx]) : 128'(0));
        chk("rsp_tmask", 128'(rsp_tmask), (idx >= 0) ? 128'(mexp[idx]) : 128'(0));
        chk("rsp_data", 128'(rsp_data), 128'(m_rsp_data()));
        chk("err_unexpected", 128'(err_unexpected), 128'(merr));
        chk("lane_d_ready", 128'(lane_d_ready), 128'({NL{mready}}));
    endtask

    task automatic clear_inputs();
        alloc_valid = 0; alloc_tag = '0; alloc_tmask = '0;
        lane_d_valid = '0; lane_d_opcode = '0; lane_d_source = '0; lane_d_data = '0;
    endtask

    task automatic tick();
        @(posedge clk);
        if (rst_n) m_edge();
        #1;
        clear_inputs();
        #1;
        check_all();
    endtask

    task automatic set_lane(input int l, input logic [2:0] op, input logic [TW-1:0] src,
                            input logic [DW-1:0] d);
        lane_d_valid[l]         = 1'b1;
        lane_d_opcode[l*3 +: 3] = op;
        lane_d_source[l*TW +: TW] = src;
        lane_d_data[l*DW +: DW] = d;
    endtask

    task automatic do_alloc(input logic [TW-1:0] t, input logic [NL-1:0] m);
        alloc_valid = 1; alloc_tag = t; alloc_tmask = m;
        tick();
    endtask

    // Drive one legal beat per lane towards some waiting slot, chosen at random.
    task automatic feed_random(input int pct);
        for (int l = 0; l < NL; l++) begin
            if ($urandom_range(0, 99) < pct) begin
                int  start = $urandom_range(0, NE-1);
                bit  done  = 0;
                for (int k = 0; k < NE; k++) begin
                    int s = (start + k) % NE;
                    if (!done && mst[s] == 1 && mexp[s][l] && !mrecv[s][l]) begin
                        set_lane(l, 3'd1, mtag[s], $urandom);
                        done = 1;
                    end
                end
            end
        end
    endtask

    initial begin
        logic [DW-1:0] d0, d2, dl0;
        int cyc;
        clear_inputs();
        rsp_ready = 0;
        rst_n = 0;
        m_reset();
        @(posedge clk);
        @(posedge clk);
        #2;
        check_all();
        chk("reset_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("reset_lane_ready", 128'(lane_d_ready), 128'(0));
        @(negedge clk);
        rst_n = 1;
        tick();
        chk("ready_after_reset", 128'(lane_d_ready), 128'(4'hF));

        // 1) all four lanes return together
        do_alloc(10'h005, 4'hF);
        set_lane(0, 3'd1, 10'h005, 32'h11);
        set_lane(1, 3'd1, 10'h005, 32'h22);
        set_lane(2, 3'd1, 10'h005, 32'h33);
        set_lane(3, 3'd1, 10'h005, 32'h44);
        tick();
        chk("t1_valid", 128'(rsp_valid), 128'(1));
        chk("t1_tag", 128'(rsp_tag), 128'(10'h005));
        chk("t1_data", 128'(rsp_data), {32'h44, 32'h33, 32'h22, 32'h11});
        rsp_ready = 1; tick(); rsp_ready = 0;
        chk("t1_fired", 128'(rsp_valid), 128'(0));

        // 2) partial mask, beats spread over time
        do_alloc(10'h00A, 4'b0101);
        d2 = $urandom; d0 = $urandom;
        set_lane(2, 3'd1, 10'h00A, d2);
        tick();
        chk("t2_wait0", 128'(rsp_valid), 128'(0));
        tick(); tick();
        chk("t2_wait2", 128'(rsp_valid), 128'(0));
        set_lane(0, 3'd1, 10'h00A, d0);
        tick();
        chk("t2_valid", 128'(rsp_valid), 128'(1));
        chk("t2_tmask", 128'(rsp_tmask), 128'(4'b0101));
        chk("t2_data", 128'(rsp_data), {32'h0, d2, 32'h0, d0});
        rsp_ready = 1; tick(); rsp_ready = 0;

        // 3) full table, response held against a lower-index completion
        for (int t = 1; t <= 4; t++) do_alloc(TW'(t), 4'b0011);
        alloc_valid = 1; alloc_tag = 10'h005; alloc_tmask = 4'hF;
        #1;
        chk("t3_alloc_full", 128'(alloc_ready), 128'(0));
        tick();
        set_lane(0, 3'd1, 10'h003, $urandom);
        set_lane(1, 3'd1, 10'h003, $urandom);
        tick();
        chk("t3_tag3", 128'(rsp_tag), 128'(10'h003));
        for (int k = 0; k < 5; k++) begin
            if (k == 1) begin
                set_lane(0, 3'd1, 10'h001, $urandom);
                set_lane(1, 3'd1, 10'h001, $urandom);
            end
            tick();
            chk("t3_hold", 128'(rsp_tag), 128'(10'h003));
        end
        rsp_ready = 1; tick(); rsp_ready = 0;
        chk("t3_next_valid", 128'(rsp_valid), 128'(1));
        chk("t3_next_tag", 128'(rsp_tag), 128'(10'h001));
        set_lane(0, 3'd1, 10'h002, $urandom);
        set_lane(1, 3'd1, 10'h002, $urandom);
        tick();
        set_lane(0, 3'd1, 10'h004, $urandom);
        set_lane(1, 3'd1, 10'h004, $urandom);
        tick();
        rsp_ready = 1; tick(); tick(); tick(); rsp_ready = 0;
        chk("t3_drained", 128'(rsp_valid), 128'(0));

        // 4) duplicate tag blocked; store ack dropped
        do_alloc(10'h007, 4'b0010);
        alloc_valid = 1; alloc_tag = 10'h007; alloc_tmask = 4'hF;
        #1;
        chk("t4_dup_tag", 128'(alloc_ready), 128'(0));
        tick();
        set_lane(1, 3'd0, 10'h007, $urandom);
        tick();
        chk("t4_ack_norsp", 128'(rsp_valid), 128'(0));
        chk("t4_ack_noerr", 128'(err_unexpected), 128'(0));
        set_lane(1, 3'd1, 10'h007, $urandom);
        tick();
        chk("t4_rsp_tag", 128'(rsp_tag), 128'(10'h007));
        rsp_ready = 1; tick(); rsp_ready = 0;

        // 5) duplicate lane beat and unknown source
        do_alloc(10'h020, 4'b0011);
        dl0 = $urandom;
        set_lane(0, 3'd1, 10'h020, dl0);
        tick();
        chk("t5_no_err_yet", 128'(err_unexpected), 128'(0));
        set_lane(0, 3'd1, 10'h020, ~dl0);
        tick();
        chk("t5_dup_err", 128'(err_unexpected), 128'(1));
        set_lane(1, 3'd1, 10'h020, 32'hCAFE);
        tick();
        chk("t5_data_kept", 128'(rsp_data), {64'h0, 32'hCAFE, dl0});
        set_lane(2, 3'd1, 10'h3FF, $urandom);
        rsp_ready = 1; tick(); rsp_ready = 0;
        chk("t5_sticky", 128'(err_unexpected), 128'(1));

        // 6) asynchronous reset mid-operation
        do_alloc(10'h030, 4'b0001);
        do_alloc(10'h031, 4'b0001);
        do_alloc(10'h032, 4'b0001);
        set_lane(0, 3'd1, 10'h030, $urandom);
        tick();
        chk("t6_pre_valid", 128'(rsp_valid), 128'(1));
        #1;
        rst_n = 0;
        #1;
        m_reset();
        chk("t6_rst_valid", 128'(rsp_valid), 128'(0));
        chk("t6_rst_err", 128'(err_unexpected), 128'(0));
        check_all();
        @(negedge clk);
        rst_n = 1;
        tick();
        for (int t = 0; t < 4; t++) begin
            alloc_valid = 1; alloc_tag = TW'(10'h030 + t); alloc_tmask = 4'b0001;
            #1;
            chk("t6_alloc_ok", 128'(alloc_ready), 128'(1));
            tick();
        end
        alloc_tag = 10'h040;
        #1;
        chk("t6_full", 128'(alloc_ready), 128'(0));
        alloc_tag = '0;

        // Random traffic against the model
        for (int c = 0; c < 400; c++) begin
            rsp_ready = ($urandom_range(0, 99) < 60);
            if ($urandom_range(0, 99) < 40) begin
                alloc_valid = 1;
                alloc_tag   = TW'($urandom_range(0, 7));
                alloc_tmask = NL'($urandom_range(0, 15));
            end
            feed_random(50);
            if ($urandom_range(0, 49) == 0)
                set_lane($urandom_range(0, NL-1), 3'($urandom_range(0, 3)),
                         TW'($urandom_range(0, 1023)), $urandom);
            tick();
        end

        rsp_ready = 1;
        cyc = 0;
        while ((rsp_valid || !alloc_ready || mst[0] != 0 || mst[1] != 0 ||
                mst[2] != 0 || mst[3] != 0) && cyc < 60) begin
            feed_random(100);
            tick();
            cyc++;
        end
        rsp_ready = 0;
        chk("drain_in_budget", 128'(cyc < 60), 128'(1));
        chk("drain_rsp_valid", 128'(rsp_valid), 128'(0));
        chk("drain_alloc_ready", 128'(alloc_ready), 128'(1));

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
